// File: rtl/mram_access_arbiter.sv
// Single-port MRAM access scheduler: round-robin between a write and a read requester,
// with a programmable post-write busy time and a bounded wait on mram_ready for reads.
module mram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [13:0]           write_delay_config_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ack_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_err_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] mram_addr_o,
  output logic [DATA_WIDTH-1:0] mram_wdata_o,
  output logic                  mram_write_en_o,
  output logic                  mram_read_en_o,
  output logic                  mram_cs_o,
  input  logic [DATA_WIDTH-1:0] mram_rdata_i,
  input  logic                  mram_ready_i,
  input  logic                  mram_pwr_on_i
);

  localparam int unsigned ToWidth = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [ToWidth-1:0] ToMax = ToWidth'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrBusy, StRdWait, StRdData} state_e;

  state_e                state_q, state_d;
  logic                  last_rd_q, last_rd_d;  // 1: last grant went to the reader
  logic [13:0]           cnt_q, cnt_d;
  logic [13:0]           dly_q, dly_d;
  logic [ToWidth-1:0]    to_q, to_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_err_q, rd_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;

  logic wr_elig, rd_elig, grant_wr, grant_rd;

  // A requester whose ack is still high is masked so it cannot be re-granted on stale req.
  always_comb begin
    wr_elig  = wr_req_i & ~wr_ack_q;
    rd_elig  = rd_req_i & ~rd_ack_q;
    grant_wr = (state_q == StIdle) & mram_pwr_on_i & wr_elig & (~rd_elig | last_rd_q);
    grant_rd = (state_q == StIdle) & mram_pwr_on_i & rd_elig & (~wr_elig | ~last_rd_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      last_rd_q <= 1'b1;
      cnt_q     <= '0;
      dly_q     <= '0;
      to_q      <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      to_q      <= to_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr)      state_d = StWrBusy;
        else if (grant_rd) state_d = StRdWait;
      end
      StWrBusy: if (cnt_q == dly_q) state_d = StIdle;
      StRdWait: begin
        if (mram_ready_i && mram_pwr_on_i) state_d = StRdData;
        else if (to_q == ToMax)            state_d = StIdle;
      end
      StRdData: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    last_rd_d = last_rd_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    to_d      = to_q;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          last_rd_d = 1'b0;
          addr_d    = wr_addr_i;
          wdata_d   = wr_data_i;
          we_d      = 1'b1;
          dly_d     = write_delay_config_i;
          cnt_d     = '0;
        end else if (grant_rd) begin
          last_rd_d = 1'b1;
          addr_d    = rd_addr_i;
          to_d      = '0;
        end
      end
      StWrBusy: begin
        if (cnt_q == dly_q) wr_ack_d = 1'b1;
        else                cnt_d    = cnt_q + 14'd1;
      end
      StRdWait: begin
        if (mram_ready_i && mram_pwr_on_i) begin
          re_d = 1'b1;
        end else if (to_q == ToMax) begin
          rd_ack_d  = 1'b1;
          rd_err_d  = 1'b1;
          rd_data_d = '0;
        end else begin
          to_d = to_q + ToWidth'(1);
        end
      end
      StRdData: begin
        rd_data_d = mram_rdata_i;
        rd_err_d  = 1'b0;
        rd_ack_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_ack_o        = wr_ack_q;
  assign rd_ack_o        = rd_ack_q;
  assign rd_data_o       = rd_data_q;
  assign rd_err_o        = rd_err_q;
  assign mram_addr_o     = addr_q;
  assign mram_wdata_o    = wdata_q;
  assign mram_write_en_o = we_q;
  assign mram_read_en_o  = re_q;
  assign mram_cs_o       = mram_pwr_on_i & (we_q | re_q);
  assign busy_o          = (state_q != StIdle);

endmodule
